// File: rtl/riscv_regfile_sb.sv
// Dual-write-port integer register file with per-register busy scoreboard.
// Latency: reads combinational; writes/issues take effect at the clock edge.
// Optional same-cycle forwarding of write data and busy-clear to both read ports.
module riscv_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we_a,
  input  logic [AW-1:0]   aa,
  input  logic [XLEN-1:0] wda,
  input  logic            we_b,
  input  logic [AW-1:0]   ab,
  input  logic [XLEN-1:0] wdb,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_rd
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  // Register 0 is only ever touched by reset, so it stays zero and never busy.
  // Port B wins a same-address collision; an issue beats a same-edge busy-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (we_b && (ab == AW'(i))) begin
          regs[i] <= wdb;
        end else if (we_a && (aa == AW'(i))) begin
          regs[i] <= wda;
        end

        if (iss_v && (iss_rd == AW'(i))) begin
          busy[i] <= 1'b1;
        end else if ((we_a && (aa == AW'(i))) || (we_b && (ab == AW'(i)))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  logic [AW-1:0]   raddr [2];
  logic [XLEN-1:0] rdata [2];
  logic            rbusy [2];
  logic            hit_a [2];
  logic            hit_b [2];
  logic            iss_hit [2];

  assign raddr[0] = a1;
  assign raddr[1] = a2;

  // Read muxing per port: x0 forced to zero, then forwarding (B over A), else the array.
  // A forwarded write clears busy unless an issue to the same register is pending,
  // in which case the registered bit is shown (issue-set is never forwarded).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit_a[p]   = (BYPASS != 0) && rst_n && we_a && (aa == raddr[p]);
      hit_b[p]   = (BYPASS != 0) && rst_n && we_b && (ab == raddr[p]);
      iss_hit[p] = iss_v && (iss_rd == raddr[p]);
      rdata[p]   = regs[raddr[p]];
      rbusy[p]   = busy[raddr[p]];
      if (raddr[p] == '0) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end else if (hit_b[p] || hit_a[p]) begin
        rdata[p] = hit_b[p] ? wdb : wda;
        rbusy[p] = iss_hit[p] ? busy[raddr[p]] : 1'b0;
      end
    end
  end

  assign rd1   = rdata[0];
  assign rd2   = rdata[1];
  assign busy1 = rbusy[0];
  assign busy2 = rbusy[1];

endmodule
